bmc_subframe_decoder: RTL and testbench
=======================================

# bmc_subframe_decoder

Parametrised biphase-mark (S/PDIF/AES3-style) subframe decoder. Consumes one half-cell per clock from the optical receive front end. Locks on X/Y/Z preambles and emits one parallel audio sample per subframe with channel index, frame counter and V/U/C status. Reports parity, coding and block-structure errors. Successor to the serial-output `biphasemark_decode`; sits between the line sampler and the audio FIFO.

## Interface
- `SAMPLE_W`, 24: output sample width, 1..24; takes MSBs of the 24-bit word {audio[19:0], aux[3:0]}.
- `NUM_CH`, 2: channels per frame, ≥2; `CH_W = $clog2(NUM_CH)`.
- `BLOCK_LEN`, 192: frames per block; `FC_W = $clog2(BLOCK_LEN)`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vin`  in  1  `din` valid this cycle.
- `din`  in  1  line half-cell.
- `sample_data`  out  SAMPLE_W  decoded sample.
- `sample_valid`  out  1  one-cycle pulse; qualifies all per-subframe outputs.
- `channel`  out  CH_W  subframe index within frame.
- `frame_counter`  out  FC_W  frame index within block.
- `v_bit`, `u_bit`, `c_bit`  out  1 each  subframe status bits.
- `parity_err`  out  1  pulse with `sample_valid`; parity failed.
- `bmc_err`  out  1  one-cycle pulse; coding violation, subframe dropped.
- `block_err`  out  1  one-cycle pulse; X preamble where Z was due.
- `locked`  out  1  level; preamble sync held.
- `cs_word`  out  32  channel-status bits 0..31 of channel 0.
- `cs_valid`  out  1  one-cycle pulse; `cs_word` updated.

## Operation
- Subframe: 64 half-cells = 4-cell preamble (8 half-cells) + 28 data cells. A half-cell is consumed only on edges with `vin`=1.
- Preambles, MSB first, accepted with either polarity:
  - Z = 8'hE8 / 8'h17: channel 0, frame 0.
  - X = 8'hE2 / 8'h1D: channel 0, other frames.
  - Y = 8'hE4 / 8'h1B: channel > 0.
- Cell decode: bit = h0 ^ h1. Require h0 != last half-cell of the previous cell; otherwise coding violation.
- Data cells, LSB first: 0..3 aux, 4..23 audio, 24 V, 25 U, 26 C, 27 P. Even parity over all 28 data bits.
- FSM:
  - HUNT: shift an 8-bit window; on any preamble match go to DATA, `locked`=1.
  - DATA: decode 56 half-cells. On violation: `bmc_err`, go to HUNT, `locked`=0. On completion: emit, go to PRE.
  - PRE: collect 8 half-cells, then compare. Match: DATA. Mismatch: HUNT, `locked`=0, no error pulse.
- `vin`=0 in any state: go to HUNT, `locked`=0, discard partial subframe, no pulse.
- `channel`: 0 on Z/X; +1 on Y, saturating at NUM_CH-1.
- `frame_counter`: 0 on Z; +1 on X, wrapping at BLOCK_LEN-1 → 0. An X arriving at BLOCK_LEN-1 pulses `block_err` and the counter wraps to 0.
- Per-subframe outputs hold their values between pulses.

## Timing
- Reset: every output 0, FSM in HUNT, counters 0.
- Latency: `sample_valid` is high the cycle after the edge that samples the 64th half-cell. Back-to-back subframes give pulses exactly 64 valid cycles apart.
- `bmc_err` pulses the cycle after the violating half-cell.
- `block_err` pulses the cycle after the X preamble completes.
- `rst_n` low mid-subframe: immediate return to reset state; no pulse when released.

## Configuration
- `BMC_DECODE_CS_CAPTURE_EN` defined:
  - Channel-0 C bits of frames 0..31 are shifted into `cs_word`; frame 0 goes to bit 0.
  - `cs_valid` pulses together with the `sample_valid` of channel 0, frame 31.
  - Capture restarts on every Z.
  - A loss of lock before frame 31 aborts the capture; `cs_word` keeps its previous value.
- Undefined: capture logic absent; `cs_word`=0 and `cs_valid`=0 constantly.

## Test plan
- Reset, then E8 followed by 56 half-cells of CC,AAAAAAAAAA,CC, `vin`=1 → one `sample_valid`; `sample_data`=24'hFFFFF0 (SAMPLE_W=24) or 16'hFFFF (SAMPLE_W=16); `channel`=0, `frame_counter`=0, V/U/C=0, no `parity_err`.
- 64'hE8_FF_FFFFFFFFFF_FF → `bmc_err` at data cell 1; no `sample_valid`; `locked`=0.
- Full block, Z then alternating Y/X, 384 subframes → 384 pulses; `channel` alternates 0/1; `frame_counter` 0..191; `block_err` never pulses.
- Same block repeated twice back-to-back → `frame_counter` returns to 0 on the second Z; no gaps between pulses; `locked` stays 1.
- Block, then `vin`=0 with `din`=1 for 384 cycles, then block → no pulses during the gap; relock on Z; second block identical to the first.
- Data with P flipped → `parity_err` pulses with `sample_valid`. Separately, 193 frames without a Z → `block_err` on X number 192 (counting from Z).

Source files
------------

// File: rtl/bmc_subframe_decoder.sv
// Biphase-mark subframe decoder: preamble lock, parallel sample out, V/U/C/P.
// Optional channel-status capture enabled by defining BMC_DECODE_CS_CAPTURE_EN.
module bmc_subframe_decoder #(
    parameter  int SAMPLE_W  = 24,
    parameter  int NUM_CH    = 2,
    parameter  int BLOCK_LEN = 192,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int FC_W      = $clog2(BLOCK_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vin,
    input  logic                din,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    output logic [CH_W-1:0]     channel,
    output logic [FC_W-1:0]     frame_counter,
    output logic                v_bit,
    output logic                u_bit,
    output logic                c_bit,
    output logic                parity_err,
    output logic                bmc_err,
    output logic                block_err,
    output logic                locked,
    output logic [31:0]         cs_word,
    output logic                cs_valid
);

    typedef enum logic [1:0] {S_HUNT, S_DATA, S_PRE} state_t;

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [2:0]          fill_q, fill_d;
    logic [7:0]          win_q, win_d;
    logic                last_q, last_d;
    logic                h0_q, h0_d;
    logic [26:0]         sr_q, sr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [FC_W-1:0]     fc_q, fc_d;
    logic                lock_q, lock_d;
    logic [SAMPLE_W-1:0] smp_q, smp_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [FC_W-1:0]     fco_q, fco_d;
    logic                vb_q, vb_d, ub_q, ub_d, cb_q, cb_d;
    logic                sv_q, sv_d, par_q, par_d;
    logic                bmc_q, bmc_d, blk_q, blk_d;

    logic [7:0]  win_n;
    logic [2:0]  kind;
    logic        bit_n;
    logic [27:0] full;
    logic        accept;

    // {Z, X, Y} match flags, either line polarity
    function automatic logic [2:0] pre_kind(input logic [7:0] w);
        pre_kind[2] = (w == 8'hE8) || (w == 8'h17);
        pre_kind[1] = (w == 8'hE2) || (w == 8'h1D);
        pre_kind[0] = (w == 8'hE4) || (w == 8'h1B);
    endfunction

    assign win_n = {win_q[6:0], din};
    assign kind  = pre_kind(win_n);
    assign bit_n = h0_q ^ din;
    assign full  = {bit_n, sr_q};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HUNT;
            cnt_q   <= '0;
            fill_q  <= '0;
            win_q   <= '0;
            last_q  <= 1'b0;
            h0_q    <= 1'b0;
            sr_q    <= '0;
            ch_q    <= '0;
            fc_q    <= '0;
            lock_q  <= 1'b0;
            smp_q   <= '0;
            chan_q  <= '0;
            fco_q   <= '0;
            vb_q    <= 1'b0;
            ub_q    <= 1'b0;
            cb_q    <= 1'b0;
            sv_q    <= 1'b0;
            par_q   <= 1'b0;
            bmc_q   <= 1'b0;
            blk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            win_q   <= win_d;
            last_q  <= last_d;
            h0_q    <= h0_d;
            sr_q    <= sr_d;
            ch_q    <= ch_d;
            fc_q    <= fc_d;
            lock_q  <= lock_d;
            smp_q   <= smp_d;
            chan_q  <= chan_d;
            fco_q   <= fco_d;
            vb_q    <= vb_d;
            ub_q    <= ub_d;
            cb_q    <= cb_d;
            sv_q    <= sv_d;
            par_q   <= par_d;
            bmc_q   <= bmc_d;
            blk_q   <= blk_d;
        end
    end

    // Hunt/data/preamble sequencing, cell decode and per-subframe outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        win_d   = win_q;
        last_d  = last_q;
        h0_d    = h0_q;
        sr_d    = sr_q;
        ch_d    = ch_q;
        fc_d    = fc_q;
        lock_d  = lock_q;
        smp_d   = smp_q;
        chan_d  = chan_q;
        fco_d   = fco_q;
        vb_d    = vb_q;
        ub_d    = ub_q;
        cb_d    = cb_q;
        sv_d    = 1'b0;
        par_d   = 1'b0;
        bmc_d   = 1'b0;
        blk_d   = 1'b0;
        accept  = 1'b0;
        if (!vin) begin
            state_d = S_HUNT;
            lock_d  = 1'b0;
            fill_d  = '0;
            cnt_d   = '0;
        end else begin
            win_d  = win_n;
            last_d = din;
            if (fill_q != 3'd7) fill_d = fill_q + 3'd1;
            unique case (state_q)
                S_HUNT: begin
                    if (fill_q == 3'd7 && |kind) accept = 1'b1;
                end
                S_DATA: begin
                    if (!cnt_q[0]) begin
                        if (din == last_q) begin
                            bmc_d   = 1'b1;
                            state_d = S_HUNT;
                            lock_d  = 1'b0;
                            fill_d  = '0;
                        end else begin
                            h0_d  = din;
                            cnt_d = cnt_q + 6'd1;
                        end
                    end else if (cnt_q == 6'd55) begin
                        sv_d    = 1'b1;
                        smp_d   = full[23 -: SAMPLE_W];
                        chan_d  = ch_q;
                        fco_d   = fc_q;
                        vb_d    = full[24];
                        ub_d    = full[25];
                        cb_d    = full[26];
                        par_d   = ^full;
                        state_d = S_PRE;
                        cnt_d   = '0;
                    end else begin
                        sr_d  = {bit_n, sr_q[26:1]};
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_PRE: begin
                    if (cnt_q == 6'd7) begin
                        if (|kind) begin
                            accept = 1'b1;
                        end else begin
                            state_d = S_HUNT;
                            lock_d  = 1'b0;
                            fill_d  = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                default: state_d = S_HUNT;
            endcase
            if (accept) begin
                state_d = S_DATA;
                cnt_d   = '0;
                lock_d  = 1'b1;
                if (kind[2]) begin
                    ch_d = '0;
                    fc_d = '0;
                end else if (kind[1]) begin
                    ch_d = '0;
                    if (fc_q == FC_W'(BLOCK_LEN - 1)) begin
                        fc_d  = '0;
                        blk_d = 1'b1;
                    end else begin
                        fc_d = fc_q + 1'b1;
                    end
                end else if (ch_q != CH_W'(NUM_CH - 1)) begin
                    ch_d = ch_q + 1'b1;
                end
            end
        end
    end

    assign sample_data   = smp_q;
    assign sample_valid  = sv_q;
    assign channel       = chan_q;
    assign frame_counter = fco_q;
    assign v_bit         = vb_q;
    assign u_bit         = ub_q;
    assign c_bit         = cb_q;
    assign parity_err    = par_q;
    assign bmc_err       = bmc_q;
    assign block_err     = blk_q;
    assign locked        = lock_q;

`ifdef BMC_DECODE_CS_CAPTURE_EN
    logic        cap_q, cap_d;
    logic [31:0] csr_q, csr_d;
    logic [31:0] csw_q, csw_d;
    logic        csv_q, csv_d;
    logic        emit, z_acc;

    assign emit  = vin && (state_q == S_DATA) && (cnt_q == 6'd55);
    assign z_acc = accept && kind[2];

    // Shift channel-0 C bits of frames 0..31; publish at frame 31
    always_comb begin
        cap_d = cap_q;
        csr_d = csr_q;
        csw_d = csw_q;
        csv_d = 1'b0;
        if (emit && cap_q && ch_q == '0) begin
            csr_d = {full[26], csr_q[31:1]};
            if (32'(fc_q) == 32'd31) begin
                csw_d = csr_d;
                csv_d = 1'b1;
                cap_d = 1'b0;
            end
        end
        if (z_acc) cap_d = 1'b1;
        if (!lock_d) cap_d = 1'b0;
    end

    // Channel-status capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= 1'b0;
            csr_q <= '0;
            csw_q <= '0;
            csv_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            csr_q <= csr_d;
            csw_q <= csw_d;
            csv_q <= csv_d;
        end
    end

    assign cs_word  = csw_q;
    assign cs_valid = csv_q;
`else
    assign cs_word  = '0;
    assign cs_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bmc_subframe_decoder.sv
// Bench for bmc_subframe_decoder: biphase stream generator with a
// per-cycle expectation queue derived from the subframe/block rules.
module tb_bmc_subframe_decoder;

    localparam int SW  = 24;
    localparam int NCH = 2;
    localparam int BL  = 192;
    localparam int CHW = $clog2(NCH);
    localparam int FCW = $clog2(BL);

    logic           clk = 1'b0;
    logic           rst_n, vin, din;
    logic [SW-1:0]  sample_data;
    logic           sample_valid;
    logic [CHW-1:0] channel;
    logic [FCW-1:0] frame_counter;
    logic           v_bit, u_bit, c_bit;
    logic           parity_err, bmc_err, block_err, locked;
    logic [31:0]    cs_word;
    logic           cs_valid;

    always #5 clk = ~clk;

    bmc_subframe_decoder #(
        .SAMPLE_W(SW),
        .NUM_CH(NCH),
        .BLOCK_LEN(BL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vin(vin),
        .din(din),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .channel(channel),
        .frame_counter(frame_counter),
        .v_bit(v_bit),
        .u_bit(u_bit),
        .c_bit(c_bit),
        .parity_err(parity_err),
        .bmc_err(bmc_err),
        .block_err(block_err),
        .locked(locked),
        .cs_word(cs_word),
        .cs_valid(cs_valid)
    );

    typedef struct {
        bit        v;
        bit        d;
        bit        sv;
        bit        bmc;
        bit        blk;
        bit        lock;
        bit        par;
        bit        vb;
        bit        ub;
        bit        cb;
        bit [23:0] smp;
        int        ch;
        int        fc;
    } step_t;

    step_t q[$];
    int    n_chk = 0;
    int    n_err = 0;
    bit    line  = 1'b0;
    bit    mlock = 1'b0;
    int    mch   = 0;
    int    mfc   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic step_t mk(input bit v, input bit d);
        step_t s;
        s = '{default: '0};
        s.v    = v;
        s.d    = d;
        s.lock = mlock;
        return s;
    endfunction

    task automatic hc(input bit d);
        q.push_back(mk(1'b1, d));
        line = d;
    endtask

    task automatic gap(input int n, input bit d);
        mlock = 1'b0;
        repeat (n) q.push_back(mk(1'b0, d));
    endtask

    // kind: 0=Z 1=X 2=Y
    task automatic pre(input int kind);
        bit [7:0] pat;
        step_t    s;
        bit       blk;
        pat = (kind == 0) ? 8'hE8 : (kind == 1) ? 8'hE2 : 8'hE4;
        if (line) pat = ~pat;
        for (int i = 7; i >= 1; i--) hc(pat[i]);
        blk = 1'b0;
        if (kind == 0) begin
            mch = 0;
            mfc = 0;
        end else if (kind == 1) begin
            mch = 0;
            if (mfc == BL - 1) begin
                mfc = 0;
                blk = 1'b1;
            end else begin
                mfc++;
            end
        end else if (mch < NCH - 1) begin
            mch++;
        end
        mlock = 1'b1;
        s = mk(1'b1, pat[0]);
        s.blk = blk;
        q.push_back(s);
        line = pat[0];
    endtask

    // 28 data cells; bad = cell with coding violation; cut = half-cells sent
    task automatic sub(input bit [27:0] w, input int bad, input int cut);
        bit    h0, h1;
        step_t s;
        for (int i = 0; i < 28; i++) begin
            if (2 * i >= cut) return;
            if (i == bad) begin
                mlock = 1'b0;
                s = mk(1'b1, line);
                s.bmc = 1'b1;
                q.push_back(s);
                return;
            end
            h0 = ~line;
            hc(h0);
            if (2 * i + 1 >= cut) return;
            h1 = w[i] ? ~h0 : h0;
            if (i < 27) begin
                hc(h1);
            end else begin
                s = mk(1'b1, h1);
                s.sv  = 1'b1;
                s.smp = w[23:0];
                s.vb  = w[24];
                s.ub  = w[25];
                s.cb  = w[26];
                s.par = ^w;
                s.ch  = mch;
                s.fc  = mfc;
                q.push_back(s);
                line = h1;
            end
        end
    endtask

    function automatic bit [27:0] mkw(input bit flip);
        bit [26:0] b;
        b = 27'($urandom);
        return {(^b) ^ flip, b};
    endfunction

    task automatic frames(input int n, input bit z);
        for (int f = 0; f < n; f++) begin
            pre((f == 0 && z) ? 0 : 1);
            sub(mkw(1'b0), -1, 56);
            pre(2);
            sub(mkw(1'b0), -1, 56);
        end
    endtask

    task automatic play();
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk);
            vin = s.v;
            din = s.d;
            @(posedge clk);
            #1;
            chk("sample_valid", sample_valid, s.sv);
            chk("bmc_err", bmc_err, s.bmc);
            chk("block_err", block_err, s.blk);
            chk("locked", locked, s.lock);
            chk("parity_err", parity_err, s.sv & s.par);
`ifndef BMC_DECODE_CS_CAPTURE_EN
            chk("cs_valid", cs_valid, 0);
`endif
            if (s.sv) begin
                chk("sample_data", sample_data, s.smp[23 -: SW]);
                chk("channel", channel, s.ch);
                chk("frame_counter", frame_counter, s.fc);
                chk("v_bit", v_bit, s.vb);
                chk("u_bit", u_bit, s.ub);
                chk("c_bit", c_bit, s.cb);
`ifndef BMC_DECODE_CS_CAPTURE_EN
                chk("cs_word", cs_word, 0);
`endif
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sample_valid"}, sample_valid, 0);
        chk({tag, "_sample_data"}, sample_data, 0);
        chk({tag, "_channel"}, channel, 0);
        chk({tag, "_frame_counter"}, frame_counter, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_bmc_err"}, bmc_err, 0);
        chk({tag, "_block_err"}, block_err, 0);
        chk({tag, "_parity_err"}, parity_err, 0);
        chk({tag, "_vuc"}, {v_bit, u_bit, c_bit}, 0);
        chk({tag, "_cs_word"}, cs_word, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [63:0] r;
        step_t     s;
        int        sel;
        rst_n = 1'b0;
        vin   = 1'b0;
        din   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Z + CC,AAAAAAAAAA,CC : all-ones audio, zero aux/V/U/C/P
        pre(0);
        sub(28'h0FFFFF0, -1, 56);
        gap(20, 1'b0);

        // E8 then all ones: violation on data cell 1
        r = 64'hE8FF_FFFF_FFFF_FFFF;
        for (int i = 63; i >= 0; i--) begin
            if (i == 56) begin
                mlock = 1'b1;
                mch = 0;
                mfc = 0;
            end
            if (i == 53) mlock = 1'b0;
            s = mk(1'b1, r[i]);
            s.bmc = (i == 53);
            q.push_back(s);
        end
        line = 1'b1;
        gap(20, 1'b1);

        // Two blocks back-to-back, then an X where Z was due
        frames(BL, 1'b1);
        frames(BL, 1'b1);
        frames(1, 1'b0);
        gap(384, 1'b1);

        // Relock after a long idle gap
        frames(40, 1'b1);

        // Random preambles with parity flips, violations and dropouts
        repeat (40) begin
            sel = $urandom_range(0, 9);
            pre($urandom_range(0, 2));
            if (sel == 0) begin
                sub(mkw(1'b0), $urandom_range(0, 27), 56);
            end else if (sel == 1) begin
                sub(mkw(1'b0), -1, $urandom_range(0, 55));
                gap($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end else begin
                sub(mkw(sel == 2), -1, 56);
            end
        end
        gap(4, 1'b0);
        play();

        // Reset asserted mid-subframe
        pre(0);
        sub(mkw(1'b0), -1, 20);
        play();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        mlock = 1'b0;
        mch   = 0;
        mfc   = 0;
        sub(mkw(1'b0), -1, 36);
        gap(3, 1'b1);
        pre(1);
        sub(mkw(1'b0), -1, 56);
        gap(2, 1'b0);
        play();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
